// File: rtl/sd_cmd_response_receiver.sv
// Serial-to-parallel receiver for 48-bit SD CMD-line responses (R1/R3/R6/R7).
// Define SD_RESP_CRC_CHECK_EN to build the CRC7 checker; leave it undefined for R3 (OCR) use.
module sd_cmd_response_receiver #(
    parameter int RESP_BITS      = 48,
    parameter int PAYLOAD_W      = 38,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 iClock_SD,
    input  logic                 iReset_n,
    input  logic                 iEnable_STP,
    input  logic                 iCmd_in,
    output logic [PAYLOAD_W-1:0] oResponse,
    output logic                 oReception_complete,
    output logic                 oNo_response,
    output logic                 oFrame_error,
    output logic                 oCrc_error,
    output logic                 oBusy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [5:0] FRAME_LEN = 6'(RESP_BITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        DONE,
        TIMEOUT
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             bitCnt_q, bitCnt_d;
    logic [TMO_W-1:0]       tmoCnt_q, tmoCnt_d;
    logic [RESP_BITS-1:0]   shift_q, shift_d;
    logic [PAYLOAD_W-1:0]   resp_q, resp_d;
    logic                   frameErr_q, frameErr_d;

`ifdef SD_RESP_CRC_CHECK_EN
    localparam logic [5:0] CRC_BITS = 6'(RESP_BITS - 8);

    logic [6:0] crc_q, crc_d;
    logic       crcErr_q, crcErr_d;

    // CRC7, polynomial x^7 + x^3 + 1, one message bit per call
    function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic bitIn);
        logic fb;
        fb = crc[6] ^ bitIn;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    logic unusedShiftBits;
    assign unusedShiftBits = shift_q[RESP_BITS-1];
`else
    logic unusedShiftBits;
    assign unusedShiftBits = ^{shift_q[RESP_BITS-1], shift_q[7:1]};
`endif

    always_ff @(posedge iClock_SD or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            tmoCnt_q   <= '0;
            shift_q    <= '0;
            resp_q     <= '0;
            frameErr_q <= 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
            crc_q      <= '0;
            crcErr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            tmoCnt_q   <= tmoCnt_d;
            shift_q    <= shift_d;
            resp_q     <= resp_d;
            frameErr_q <= frameErr_d;
`ifdef SD_RESP_CRC_CHECK_EN
            crc_q      <= crc_d;
            crcErr_q   <= crcErr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        tmoCnt_d   = tmoCnt_q;
        shift_d    = shift_q;
        resp_d     = resp_q;
        frameErr_d = frameErr_q;
`ifdef SD_RESP_CRC_CHECK_EN
        crc_d      = crc_q;
        crcErr_d   = crcErr_q;
`endif

        case (state_q)
            IDLE: begin
                if (iEnable_STP) begin
                    state_d  = WAIT_START;
                    bitCnt_d = '0;
                    tmoCnt_d = '0;
                    shift_d  = '0;
`ifdef SD_RESP_CRC_CHECK_EN
                    crc_d    = '0;
`endif
                end
            end

            // Abort beats everything; a start bit on the last timeout cycle beats the timeout
            WAIT_START: begin
                if (!iEnable_STP) begin
                    state_d = IDLE;
                end else if (!iCmd_in) begin
                    state_d  = RECEIVE;
                    shift_d  = {shift_q[RESP_BITS-2:0], iCmd_in};
                    bitCnt_d = 6'd1;
`ifdef SD_RESP_CRC_CHECK_EN
                    crc_d    = crc7Step(crc_q, iCmd_in);
`endif
                end else if (tmoCnt_q == TMO_LAST) begin
                    state_d = TIMEOUT;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end

            // The end bit is sampled with bitCnt_q == FRAME_LEN-1; results register one edge later
            RECEIVE: begin
                if (!iEnable_STP) begin
                    state_d = IDLE;
                end else if (bitCnt_q == FRAME_LEN) begin
                    state_d    = DONE;
                    resp_d     = shift_q[RESP_BITS-3:8];
                    frameErr_d = shift_q[RESP_BITS-2] | ~shift_q[0];
`ifdef SD_RESP_CRC_CHECK_EN
                    crcErr_d   = (shift_q[7:1] != crc_q);
`endif
                end else begin
                    shift_d  = {shift_q[RESP_BITS-2:0], iCmd_in};
                    bitCnt_d = bitCnt_q + 1'b1;
`ifdef SD_RESP_CRC_CHECK_EN
                    if (bitCnt_q < CRC_BITS) begin
                        crc_d = crc7Step(crc_q, iCmd_in);
                    end
`endif
                end
            end

            DONE, TIMEOUT: begin
                if (!iEnable_STP) begin
                    state_d    = IDLE;
                    resp_d     = '0;
                    frameErr_d = 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
                    crcErr_d   = 1'b0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oResponse           = resp_q;
    assign oReception_complete = (state_q == DONE);
    assign oNo_response        = (state_q == TIMEOUT);
    assign oFrame_error        = frameErr_q;
    assign oBusy               = (state_q == WAIT_START) || (state_q == RECEIVE);
`ifdef SD_RESP_CRC_CHECK_EN
    assign oCrc_error          = crcErr_q;
`else
    assign oCrc_error          = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_response_receiver.sv
// Directed testbench for sd_cmd_response_receiver: table of response frames plus
// hand-written timeout, abort and async-reset sequences.
module tb_sd_cmd_response_receiver;

    logic        clock;
    logic        resetN;
    logic        enable;
    logic        cmdIn;
    logic [37:0] response;
    logic        complete;
    logic        noResponse;
    logic        frameError;
    logic        crcError;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [47:0] frame;
        int          preWait;
        logic [37:0] expResp;
        logic        expFrameErr;
        logic        expCrcErr;
    } vec_t;

    vec_t vecs[6];

    sd_cmd_response_receiver dut (
        .iClock_SD          (clock),
        .iReset_n           (resetN),
        .iEnable_STP        (enable),
        .iCmd_in            (cmdIn),
        .oResponse          (response),
        .oReception_complete(complete),
        .oNo_response       (noResponse),
        .oFrame_error       (frameError),
        .oCrc_error         (crcError),
        .oBusy              (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_complete"}, 64'(complete), 64'd0);
        checkOutput({tag, "_noresp"}, 64'(noResponse), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_resp"}, 64'(response), 64'd0);
        checkOutput({tag, "_frameerr"}, 64'(frameError), 64'd0);
        checkOutput({tag, "_crcerr"}, 64'(crcError), 64'd0);
    endtask

    task automatic sendBits(input logic [47:0] frame, input int first, input int last);
        for (int b = first; b <= last; b++) begin
            cmdIn = frame[47-b];
            tick();
        end
        cmdIn = 1'b1;
    endtask

    // One full enable / frame / release cycle for a table entry
    task automatic applyStimulus(input int idx);
        vec_t  v;
        logic  expCrc;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("v%0d", idx);
`ifdef SD_RESP_CRC_CHECK_EN
        expCrc = v.expCrcErr;
`else
        expCrc = 1'b0;
`endif
        enable = 1'b1;
        cmdIn  = 1'b1;
        tick();
        checkOutput({tag, "_busy_wait"}, 64'(busy), 64'd1);
        repeat (v.preWait) tick();
        sendBits(v.frame, 0, 47);
        checkOutput({tag, "_complete_early"}, 64'(complete), 64'd0);
        tick();
        checkOutput({tag, "_complete"}, 64'(complete), 64'd1);
        checkOutput({tag, "_resp"}, 64'(response), 64'(v.expResp));
        checkOutput({tag, "_frameerr"}, 64'(frameError), 64'(v.expFrameErr));
        checkOutput({tag, "_crcerr"}, 64'(crcError), 64'(expCrc));
        checkOutput({tag, "_busy_done"}, 64'(busy), 64'd0);
        tick();
        checkOutput({tag, "_complete_held"}, 64'(complete), 64'd1);
        enable = 1'b0;
        tick();
        checkIdle({tag, "_released"});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{48'h08_0000_01AA_13, 5, 38'h08_0000_01AA, 1'b0, 1'b0};
        vecs[1] = '{48'h08_0000_01AB_13, 0, 38'h08_0000_01AB, 1'b0, 1'b1};
        vecs[2] = '{48'h00_0000_0000_00, 2, 38'h00_0000_0000, 1'b1, 1'b0};
        vecs[3] = '{48'h08_0000_01AA_12, 1, 38'h08_0000_01AA, 1'b1, 1'b0};
        vecs[4] = '{48'h08_0000_01AA_15, 3, 38'h08_0000_01AA, 1'b0, 1'b1};
        vecs[5] = '{48'h48_0000_01AA_87, 7, 38'h08_0000_01AA, 1'b1, 1'b0};

        resetN = 1'b0;
        enable = 1'b0;
        cmdIn  = 1'b1;
        #12;
        checkIdle("reset");
        resetN = 1'b1;
        tick();
        checkIdle("idle");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i);
        end

        // No start bit: 64 clocks in WAIT_START then no-response, held until release
        enable = 1'b1;
        tick();
        repeat (63) tick();
        checkOutput("tmo_noresp_early", 64'(noResponse), 64'd0);
        checkOutput("tmo_busy_early", 64'(busy), 64'd1);
        tick();
        checkOutput("tmo_noresp", 64'(noResponse), 64'd1);
        checkOutput("tmo_complete", 64'(complete), 64'd0);
        checkOutput("tmo_resp", 64'(response), 64'd0);
        checkOutput("tmo_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        checkOutput("tmo_noresp_held", 64'(noResponse), 64'd1);
        enable = 1'b0;
        tick();
        checkIdle("tmo_released");

        // Start bit arriving on the last timeout cycle must win
        enable = 1'b1;
        tick();
        repeat (63) tick();
        cmdIn = 1'b0;
        tick();
        checkOutput("race_noresp", 64'(noResponse), 64'd0);
        checkOutput("race_busy", 64'(busy), 64'd1);
        sendBits(vecs[0].frame, 1, 47);
        tick();
        checkOutput("race_complete", 64'(complete), 64'd1);
        checkOutput("race_resp", 64'(response), 64'(vecs[0].expResp));
        enable = 1'b0;
        tick();

        // Abort after 20 frame bits, then a clean frame
        enable = 1'b1;
        tick();
        sendBits(vecs[0].frame, 0, 19);
        checkOutput("abort_busy_before", 64'(busy), 64'd1);
        enable = 1'b0;
        tick();
        checkIdle("abort");
        repeat (2) tick();
        checkIdle("abort_settled");
        applyStimulus(0);

        // Async reset between edges in the middle of a frame
        enable = 1'b1;
        tick();
        sendBits(vecs[0].frame, 0, 29);
        checkOutput("areset_busy_before", 64'(busy), 64'd1);
        #2;
        resetN = 1'b0;
        #1;
        checkIdle("areset");
        enable = 1'b0;
        #2;
        resetN = 1'b1;
        tick();
        checkIdle("areset_released");
        applyStimulus(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
